// File: rtl/floating_point_unit.sv
// floating_point_unit: binary16 adder/subtractor with a registered result.
// Computes a + b (dec=0) or a - b (dec=1). Rounds to nearest, ties to even,
// with gradual underflow. There is one cycle of latency, and en stalls the
// result register.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset; clears result to 0x0000
//   en      load enable for the result register
//   dec     0 = add, 1 = subtract (inverts b's sign)
//   a, b    binary16 operands
//   result  registered binary16 result
// Only DATA_WIDTH = 16 is supported.
module floating_point_unit #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dec,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned SIG_W  = FRAC_W + 1;   // hidden bit + fraction
  localparam int unsigned EXT_W  = SIG_W + 3;    // + guard, round, sticky
  localparam int unsigned WIDE_W = 2 * EXT_W;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] INF_MAG = 16'h7C00;

  // Leading-zero count of a 14-bit value (14 when the value is zero)
  function automatic logic [3:0] lzc14(input logic [EXT_W-1:0] v);
    lzc14 = 4'(EXT_W);
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (v[i]) lzc14 = 4'(int'(EXT_W) - 1 - i);
    end
  endfunction

  // Operand decode
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb, eea, eeb;
  logic [FRAC_W-1:0] fa, fb;
  logic [SIG_W-1:0]  siga, sigb;
  logic              nan_a, nan_b, inf_a, inf_b;

  assign sa    = a[15];
  assign sb    = b[15] ^ dec;
  assign ea    = a[14:10];
  assign eb    = b[14:10];
  assign fa    = a[9:0];
  assign fb    = b[9:0];
  assign eea   = (ea == '0) ? EXP_W'(1) : ea;
  assign eeb   = (eb == '0) ? EXP_W'(1) : eb;
  assign siga  = {(ea != '0), fa};
  assign sigb  = {(eb != '0), fb};
  assign nan_a = (ea == '1) && (fa != '0);
  assign nan_b = (eb == '1) && (fb != '0);
  assign inf_a = (ea == '1) && (fa == '0);
  assign inf_b = (eb == '1) && (fb == '0);

  // Datapath intermediates
  logic              swap;
  logic              sx, sy;
  logic [EXP_W-1:0]  ex, ey, diff, max_sh, sh;
  logic [SIG_W-1:0]  sigx, sigy;
  logic [WIDE_W-1:0] wide;
  logic [EXT_W-1:0]  xm, ym, m;
  logic [EXT_W:0]    sum;
  logic [3:0]        lz;
  logic [5:0]        exp_n, exp_r;
  logic              round_up;
  logic [SIG_W:0]    mant;
  logic [FRAC_W-1:0] frac_r;
  logic [15:0]       next_result;

  // Align, add/subtract, normalize, round and pick special cases
  always_comb begin
    swap        = 1'b0;
    sx          = 1'b0;
    sy          = 1'b0;
    ex          = '0;
    ey          = '0;
    sigx        = '0;
    sigy        = '0;
    diff        = '0;
    wide        = '0;
    xm          = '0;
    ym          = '0;
    sum         = '0;
    lz          = '0;
    max_sh      = '0;
    sh          = '0;
    m           = '0;
    exp_n       = '0;
    exp_r       = '0;
    round_up    = 1'b0;
    mant        = '0;
    frac_r      = '0;
    next_result = '0;

    // Encoded magnitudes order the same way as the values they represent
    swap = (b[14:0] > a[14:0]);
    sx   = swap ? sb   : sa;
    sy   = swap ? sa   : sb;
    ex   = swap ? eeb  : eea;
    ey   = swap ? eea  : eeb;
    sigx = swap ? sigb : siga;
    sigy = swap ? siga : sigb;
    diff = ex - ey;

    // Sticky is folded into the LSB of the aligned smaller operand
    wide = {sigy, 3'b000, WIDE_W'(0)} >> 0;
    wide = {sigy, 3'b000, EXT_W'(0)} >> diff;
    if (diff >= EXP_W'(EXT_W)) begin
      ym = {13'd0, |sigy};
    end else begin
      ym = {wide[WIDE_W-1:EXT_W+1], wide[EXT_W] | (|wide[EXT_W-1:0])};
    end
    xm = {sigx, 3'b000};

    sum = (sx == sy) ? ({1'b0, xm} + {1'b0, ym}) : ({1'b0, xm} - {1'b0, ym});

    // Left shift stops once the exponent reaches 1 (gradual underflow)
    lz     = lzc14(sum[EXT_W-1:0]);
    max_sh = ex - EXP_W'(1);
    sh     = (EXP_W'(lz) < max_sh) ? EXP_W'(lz) : max_sh;

    if (sum[EXT_W]) begin
      m     = {sum[EXT_W:2], sum[1] | sum[0]};
      exp_n = 6'(ex) + 6'd1;
    end else begin
      m     = sum[EXT_W-1:0] << sh;
      exp_n = 6'(ex) - 6'(sh);
    end

    round_up = m[2] & (m[3] | m[1] | m[0]);
    mant     = {1'b0, m[EXT_W-1:3]} + (SIG_W+1)'(round_up);

    // Rounding carry renormalizes; a cleared hidden bit means subnormal
    if (mant[SIG_W]) begin
      exp_r  = exp_n + 6'd1;
      frac_r = mant[SIG_W-1:1];
    end else begin
      exp_r  = mant[SIG_W-1] ? exp_n : 6'd0;
      frac_r = mant[FRAC_W-1:0];
    end

    if (nan_a || nan_b) begin
      next_result = QNAN;
    end else if (inf_a && inf_b && (sa != sb)) begin
      next_result = QNAN;
    end else if (inf_a) begin
      next_result = {sa, INF_MAG[14:0]};
    end else if (inf_b) begin
      next_result = {sb, INF_MAG[14:0]};
    end else if (sum == '0) begin
      next_result = (sa && sb) ? 16'h8000 : 16'h0000;
    end else if (exp_r >= 6'd31) begin
      next_result = {sx, INF_MAG[14:0]};
    end else begin
      next_result = {sx, exp_r[EXP_W-1:0], frac_r};
    end
  end

  // Result register: the only state in the block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (en) begin
      result <= DATA_WIDTH'(next_result);
    end
  end

endmodule

// File: tb/tb_floating_point_unit.sv
// Self-checking bench for floating_point_unit. It uses a table of directed
// vectors, hand-written control sequences, and random vectors checked against
// an exact-integer reference model. Expected values are queued when
// stimulus is driven and compared when the result appears.
module tb_floating_point_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        dec;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

  floating_point_unit #(.DATA_WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .dec    (dec),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        dec;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, want);
    end
  endtask

  // Value in units of 2^-24, which makes every binary16 value an integer
  function automatic longint decode(input logic [15:0] v);
    longint k;
    if (v[14:10] == 5'd0) k = longint'(v[9:0]);
    else k = longint'({1'b1, v[9:0]}) << (int'(v[14:10]) - 1);
    return v[15] ? -k : k;
  endfunction

  // Reference: exact integer sum, then round-to-nearest-even into binary16
  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic d);
    logic [15:0] yy;
    logic        nx, ny, ix, iy, neg;
    longint      s, mag, ulp, q, rem;
    int          p, field;
    yy = y;
    yy[15] = y[15] ^ d;
    nx = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    ny = (yy[14:10] == 5'h1F) && (yy[9:0] != 0);
    ix = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    iy = (yy[14:10] == 5'h1F) && (yy[9:0] == 0);
    if (nx || ny) return 16'h7E00;
    if (ix && iy && (x[15] != yy[15])) return 16'h7E00;
    if (ix) return x;
    if (iy) return yy;
    s = decode(x) + decode(yy);
    if (s == 0) return (x[15] && yy[15]) ? 16'h8000 : 16'h0000;
    neg = (s < 0);
    mag = neg ? -s : s;
    if (mag < 1024) return {neg, 5'd0, 10'(mag)};
    p = 10;
    for (int i = 10; i < 62; i++) if ((mag >> i) != 0) p = i;
    ulp = longint'(1) << (p - 10);
    q   = mag >> (p - 10);
    rem = mag & (ulp - 1);
    if ((2 * rem > ulp) || ((2 * rem == ulp) && q[0])) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      p = p + 1;
    end
    field = p - 9;
    if (field >= 31) return {neg, 15'h7C00};
    return {neg, 5'(field), 10'(q)};
  endfunction

  // One enabled operation: queue the expectation, clock, then compare
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic td, input logic [15:0] te, input string name);
    a = ta;
    b = tb_v;
    dec = td;
    en = 1'b1;
    exp_q.push_back(te);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 16'h0000, 16'hFFFF);
    end else begin
      check(name, result, exp_q.pop_front());
    end
    last_exp = te;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h4200, 16'hC600, 1'b0, 16'hC200});
    vecs.push_back('{16'h4200, 16'hC600, 1'b1, 16'h4880});
    vecs.push_back('{16'h3C00, 16'h3C00, 1'b0, 16'h4000});
    vecs.push_back('{16'h4200, 16'h4200, 1'b1, 16'h0000});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h8000});
    vecs.push_back('{16'h3C00, 16'h1000, 1'b0, 16'h3C00});
    vecs.push_back('{16'h3C01, 16'h1000, 1'b0, 16'h3C02});
    vecs.push_back('{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00});
    vecs.push_back('{16'h7C00, 16'h7C00, 1'b1, 16'h7E00});
    vecs.push_back('{16'h7E01, 16'h3C00, 1'b0, 16'h7E00});
    vecs.push_back('{16'hFC00, 16'h4000, 1'b0, 16'hFC00});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002});
    vecs.push_back('{16'h0400, 16'h0001, 1'b1, 16'h03FF});
    vecs.push_back('{16'h03FF, 16'h0001, 1'b0, 16'h0400});
    vecs.push_back('{16'h8000, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{16'h0000, 16'h8000, 1'b1, 16'h0000});
    vecs.push_back('{16'h7C00, 16'h7C00, 1'b0, 16'h7C00});
    vecs.push_back('{16'h3C00, 16'hFC00, 1'b0, 16'hFC00});
    vecs.push_back('{16'h3C00, 16'h7C00, 1'b1, 16'hFC00});
    vecs.push_back('{16'h0001, 16'h0001, 1'b1, 16'h0000});

    reset = 1'b0;
    en    = 1'b1;
    dec   = 1'b0;
    a     = 16'h4200;
    b     = 16'hC600;
    last_exp = 16'h0000;

    // Held in reset across edges with en=1 and live operands
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", result, 16'h0000);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].dec, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Enable low: result holds while the operands change
    run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, "hold_load");
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a   = 16'h5000 + 16'(c);
      b   = 16'hC123;
      dec = c[0];
      @(posedge clk);
      #1;
      check($sformatf("hold_c%0d", c), result, 16'h4000);
    end

    // Asynchronous reset between edges, then discard of a pending operation
    run_op(16'h4200, 16'h4200, 1'b0, 16'h4600, "pre_async");
    a   = 16'h3C00;
    b   = 16'h3C00;
    dec = 1'b0;
    en  = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", result, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_discard", result, 16'h0000);
    reset = 1'b1;
    last_exp = 16'h0000;
    run_op(16'h4200, 16'hC600, 1'b1, 16'h4880, "post_reset");

    // Random back-to-back stream with random stalls
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra, rb, re;
      logic        rd, ren;
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      if (n % 3 == 0) rb[14:10] = ra[14:10] - 5'($urandom_range(0, 2));
      rd  = 1'($urandom_range(0, 1));
      ren = ($urandom_range(0, 3) != 0);
      a   = ra;
      b   = rb;
      dec = rd;
      en  = ren;
      re  = ren ? ref_add(ra, rb, rd) : last_exp;
      exp_q.push_back(re);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("rand_queue", 16'h0000, 16'hFFFF);
      end else begin
        check($sformatf("rand%0d a=%04h b=%04h dec=%0b en=%0b", n, ra, rb, rd, ren),
              result, exp_q.pop_front());
      end
      last_exp = re;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
